// File: rtl/systolic_mm_tile_ctrl.sv
// Output-stationary R x C systolic tile: latches both operand tiles on start, skews them internally, drains one row per beat.
// First out_valid arrives K+R+C-1 cycles after start acceptance; out_row/out_data hold stable while out_ready is low.
module systolic_mm_tile_ctrl #(
  parameter int N  = 8,
  parameter int M  = 20,
  parameter int R  = 4,
  parameter int C  = 4,
  parameter int K  = 9,
  parameter int RW = (R > 1) ? $clog2(R) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic             acc_en,
  input  logic [R*K*N-1:0] a_in,
  input  logic [C*K*N-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_row,
  output logic [C*M-1:0]   out_data,
  output logic             sat_flag
);

  localparam int TLAST = K + R + C - 3;
  localparam int TW    = (TLAST > 0) ? $clog2(TLAST + 1) : 1;
  localparam int PW    = 2 * N;
  localparam int CP    = (C > 1) ? C - 1 : 1;
  localparam int RP    = (R > 1) ? R - 1 : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    t;
  logic [R*K*N-1:0] a_q;
  logic [C*K*N-1:0] b_q;
  logic             sgn_q;

  logic [N-1:0]     a_pass  [R][CP];
  logic [N-1:0]     b_pass  [RP][C];
  logic [N-1:0]     a_cur   [R][C];
  logic [N-1:0]     b_cur   [R][C];
  logic [M-1:0]     acc     [R][C];
  logic [M-1:0]     acc_nxt [R][C];
  logic             sat_any;

  logic             feed_last;
  logic             beat;
  logic             last_beat;
  logic [RW-1:0]    load_row;
  logic [C*M-1:0]   load_data;

  // Returns {saturated, clamped sum} of one multiply-accumulate step.
  function automatic logic [M:0] mac(input logic [M-1:0] acc_v, input logic [N-1:0] a,
                                     input logic [N-1:0] b, input logic s);
    logic [PW-1:0] prod;
    logic [M-1:0]  prod_x;
    logic [M:0]    sum;
    logic          ovf;
    logic [M-1:0]  res;
    if (s) begin
      prod   = PW'($signed(a)) * PW'($signed(b));
      prod_x = M'($signed(prod));
      sum    = (M+1)'($signed(acc_v)) + (M+1)'($signed(prod_x));
      ovf    = sum[M] ^ sum[M-1];
      res    = ovf ? {sum[M], {(M-1){~sum[M]}}} : sum[M-1:0];
    end else begin
      prod   = PW'(a) * PW'(b);
      prod_x = M'(prod);
      sum    = (M+1)'(acc_v) + (M+1)'(prod_x);
      ovf    = sum[M];
      res    = ovf ? '1 : sum[M-1:0];
    end
    return {ovf, res};
  endfunction

  assign feed_last = (t == TW'(TLAST));
  assign beat      = out_valid & out_ready;
  assign last_beat = beat && (out_row == RW'(R - 1));
  assign load_row  = out_valid ? out_row + RW'(1) : '0;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED: begin
        busy = 1'b1;
        if (feed_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge injection: row r carries a[r][t-r], column c carries b[c][t-c]; interior PEs see the neighbour's register.
  always_comb begin
    int k;
    k = 0;
    for (int r = 0; r < R; r++) begin
      k = int'(t) - r;
      a_cur[r][0] = '0;
      if (state == FEED && k >= 0 && k < K) a_cur[r][0] = a_q[(r*K+k)*N +: N];
      for (int c = 1; c < C; c++) a_cur[r][c] = a_pass[r][c-1];
    end
    for (int c = 0; c < C; c++) begin
      k = int'(t) - c;
      b_cur[0][c] = '0;
      if (state == FEED && k >= 0 && k < K) b_cur[0][c] = b_q[(c*K+k)*N +: N];
      for (int r = 1; r < R; r++) b_cur[r][c] = b_pass[r-1][c];
    end
  end

  always_comb begin
    logic [M:0] res;
    res     = '0;
    sat_any = 1'b0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        res           = mac(acc[r][c], a_cur[r][c], b_cur[r][c], sgn_q);
        acc_nxt[r][c] = res[M-1:0];
        sat_any       = sat_any | res[M];
      end
    end
  end

  always_comb begin
    load_data = '0;
    for (int c = 0; c < C; c++) load_data[c*M +: M] = acc[load_row][c];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      t         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      sat_flag  <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) acc[r][c] <= '0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C - 1; c++) a_pass[r][c] <= '0;
      for (int r = 0; r < R - 1; r++)
        for (int c = 0; c < C; c++) b_pass[r][c] <= '0;
    end else begin
      done <= 1'b0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C - 1; c++) a_pass[r][c] <= a_cur[r][c];
      for (int r = 0; r < R - 1; r++)
        for (int c = 0; c < C; c++) b_pass[r][c] <= b_cur[r][c];
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            sgn_q    <= sgn;
            sat_flag <= 1'b0;
            t        <= '0;
            if (!acc_en)
              for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) acc[r][c] <= '0;
          end
        end
        FEED: begin
          t <= feed_last ? '0 : t + TW'(1);
          for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) acc[r][c] <= acc_nxt[r][c];
          if (sat_any) sat_flag <= 1'b1;
        end
        DRAIN: begin
          // First DRAIN cycle loads row 0 from the accumulators settled on the last FEED edge.
          if (!out_valid || beat) begin
            if (last_beat) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_valid <= 1'b1;
              out_row   <= load_row;
              out_data  <= load_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_tile_ctrl.sv
// Directed bench for systolic_mm_tile_ctrl: two instances (M=20 and M=16) share stimulus,
// expected rows come from an independent dot-product model via a scoreboard queue.
module tb_systolic_mm_tile_ctrl;
  localparam int N  = 8;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int K  = 3;
  localparam int MA = 20;
  localparam int MB = 16;
  localparam int RW = 1;
  localparam int AW = R*K*N;
  localparam int BW = C*K*N;
  localparam int LAT = K + R + C - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sgn = 1'b0;
  logic acc_en = 1'b0;
  logic out_ready = 1'b0;
  logic [AW-1:0] a_in = '0;
  logic [BW-1:0] b_in = '0;

  logic busy_a, done_a, valid_a, sat_a;
  logic [RW-1:0] row_a;
  logic [C*MA-1:0] data_a;
  logic busy_b, done_b, valid_b, sat_b;
  logic [RW-1:0] row_b;
  logic [C*MB-1:0] data_b;

  typedef struct packed {
    logic [RW-1:0]   row;
    logic [C*MA-1:0] da;
    logic [C*MB-1:0] db;
  } exp_t;

  exp_t sbq[$];
  logic [MA-1:0] ma [R][C];
  logic [MA-1:0] mb [R][C];
  bit msat_a, msat_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_mm_tile_ctrl #(.N(N), .M(MA), .R(R), .C(C), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .acc_en(acc_en),
    .a_in(a_in), .b_in(b_in), .busy(busy_a), .done(done_a),
    .out_valid(valid_a), .out_ready(out_ready), .out_row(row_a),
    .out_data(data_a), .sat_flag(sat_a));

  systolic_mm_tile_ctrl #(.N(N), .M(MB), .R(R), .C(C), .K(K)) dut_m16 (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .acc_en(acc_en),
    .a_in(a_in), .b_in(b_in), .busy(busy_b), .done(done_b),
    .out_valid(valid_b), .out_ready(out_ready), .out_row(row_b),
    .out_data(data_b), .sat_flag(sat_b));

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K*N-1:0] mk3(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    return {x2, x1, x0};
  endfunction

  function automatic logic [MA:0] ref_mac(input logic [MA-1:0] acc, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input bit s, input int mw);
    longint m, v, p, lo, hi, sum;
    bit f;
    m = (longint'(1) <<< mw) - 1;
    v = longint'(acc) & m;
    if (s) begin
      if (v[mw-1]) v = v - (longint'(1) <<< mw);
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = -(longint'(1) <<< (mw-1));
      hi = (longint'(1) <<< (mw-1)) - 1;
    end else begin
      p  = longint'(a) * longint'(b);
      lo = 0;
      hi = m;
    end
    sum = v + p;
    f = 1'b0;
    if (sum > hi) begin sum = hi; f = 1'b1; end
    else if (sum < lo) begin sum = lo; f = 1'b1; end
    return {f, MA'(sum & m)};
  endfunction

  task automatic model_tile(input logic [AW-1:0] av, input logic [BW-1:0] bv, input bit s, input bit en);
    logic [MA:0] res;
    exp_t e;
    msat_a = 1'b0;
    msat_b = 1'b0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (!en) begin ma[r][c] = '0; mb[r][c] = '0; end
        for (int k = 0; k < K; k++) begin
          res = ref_mac(ma[r][c], av[(r*K+k)*N +: N], bv[(c*K+k)*N +: N], s, MA);
          ma[r][c] = res[MA-1:0];
          msat_a |= res[MA];
          res = ref_mac(mb[r][c], av[(r*K+k)*N +: N], bv[(c*K+k)*N +: N], s, MB);
          mb[r][c] = res[MA-1:0];
          msat_b |= res[MA];
        end
      end
    end
    for (int r = 0; r < R; r++) begin
      e = '0;
      e.row = RW'(r);
      for (int c = 0; c < C; c++) begin
        e.da[c*MA +: MA] = ma[r][c];
        e.db[c*MB +: MB] = mb[r][c][MB-1:0];
      end
      sbq.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_tile(input logic [AW-1:0] av, input logic [BW-1:0] bv, input bit s, input bit en);
    a_in = av; b_in = bv; sgn = s; acc_en = en; start = 1'b1;
    model_tile(av, bv, s, en);
    @(negedge clk);
    start = 1'b0;
    a_in = AW'({$urandom, $urandom});
    b_in = BW'({$urandom, $urandom});
    sgn = ~s;
    acc_en = ~en;
    check("busy_after_accept", busy_a, 1);
    check("busy_after_accept_m16", busy_b, 1);
    check("done_low_after_accept", done_a, 0);
    check("sat_cleared_on_start", sat_a, 0);
    check("sat_cleared_on_start_m16", sat_b, 0);
  endtask

  task automatic drain(input int stall_row, input int exp_lat);
    exp_t e;
    int n;
    for (int i = 0; i < R; i++) begin
      n = 0;
      while (valid_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("out_valid_seen", valid_a, 1);
      check("out_valid_seen_m16", valid_b, 1);
      if (i == 0 && exp_lat >= 0) check("first_valid_latency", n, exp_lat);
      check("scoreboard_underflow", sbq.size() == 0, 0);
      e = (sbq.size() > 0) ? sbq.pop_front() : '0;
      check("out_row", row_a, e.row);
      check("out_data", data_a, e.da);
      check("out_row_m16", row_b, e.row);
      check("out_data_m16", data_b, e.db);
      if (i == stall_row) begin
        for (int j = 0; j < 5; j++) begin
          if (j == 1) begin start = 1'b1; a_in = '1; end
          if (j == 2) start = 1'b0;
          @(negedge clk);
          check("stall_valid", valid_a, 1);
          check("stall_row", row_a, e.row);
          check("stall_data", data_a, e.da);
          check("stall_busy", busy_a, 1);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("done_pulse", done_a, 1);
    check("done_pulse_m16", done_b, 1);
    check("valid_low_after_last", valid_a, 0);
    check("busy_low_after_last", busy_a, 0);
    check("sat_flag", sat_a, msat_a);
    check("sat_flag_m16", sat_b, msat_b);
  endtask

  logic [AW-1:0] s1_a, ff_a, sat_av, mix_a;
  logic [BW-1:0] s1_b, two_b, sat_bv, mix_b;

  initial begin
    int cnt_v, cnt_d;
    s1_a   = {mk3(8'd0, 8'd1, 8'd0), mk3(8'd1, 8'd0, 8'd0)};
    s1_b   = {mk3(8'd8, 8'd9, 8'd10), mk3(8'd5, 8'd6, 8'd7)};
    ff_a   = '1;
    two_b  = {C*K{8'd2}};
    sat_av = {R*K{8'h80}};
    sat_bv = {C*K{8'h80}};
    mix_a  = {mk3(8'h84, 8'h00, 8'h07), mk3(8'hFD, 8'h01, 8'h02)};
    mix_b  = {mk3(8'd9, 8'hF8, 8'd5), mk3(8'd1, 8'd2, 8'd3)};
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin ma[r][c] = '0; mb[r][c] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_valid", valid_a, 0);
    check("reset_row", row_a, 0);
    check("reset_data", data_a, 0);
    check("reset_sat", sat_a, 0);
    check("reset_valid_m16", valid_b, 0);
    rst = 1'b1;
    @(negedge clk);

    // Identity tile with latency check, then accumulate / clear
    start_tile(s1_a, s1_b, 1'b0, 1'b0);
    drain(-1, LAT);
    start_tile(s1_a, s1_b, 1'b0, 1'b1);
    drain(-1, LAT);
    start_tile(s1_a, s1_b, 1'b0, 1'b0);
    drain(-1, LAT);

    // Sign mode
    start_tile(ff_a, two_b, 1'b1, 1'b0);
    drain(-1, LAT);
    start_tile(ff_a, two_b, 1'b0, 1'b0);
    drain(-1, LAT);

    // Saturation (M=16 instance clamps, M=20 does not)
    start_tile(sat_av, sat_bv, 1'b1, 1'b0);
    drain(-1, LAT);

    // Backpressure plus ignored start pulses during FEED and DRAIN
    start_tile(mix_a, mix_b, 1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(0, -1);
    cnt_v = 0;
    cnt_d = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt_d += int'(done_a);
      cnt_v += int'(busy_a);
    end
    check("no_second_done", cnt_d, 0);
    check("no_restart_busy", cnt_v, 0);

    // Reset mid-FEED at t=2
    start_tile(s1_a, s1_b, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    check("midreset_busy", busy_a, 0);
    check("midreset_valid", valid_a, 0);
    check("midreset_sat", sat_a, 0);
    check("midreset_done", done_a, 0);
    check("midreset_data", data_a, 0);
    cnt_v = 0;
    cnt_d = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt_d += int'(done_a);
      cnt_v += int'(valid_a);
    end
    check("midreset_no_done", cnt_d, 0);
    check("midreset_no_valid", cnt_v, 0);
    start_tile(s1_a, s1_b, 1'b0, 1'b1);
    drain(-1, LAT);

    check("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_mm_tile_ctrl.md
Name: systolic_mm_tile_ctrl

Overview:
Parametrised, self-sequencing successor to the systolic matrix-multiply top. It latches one R×K operand tile (filters) and one C×K operand tile (image vectors), then generates the operand skew internally. It runs an R×C output-stationary PE array and drains results one row per beat over a valid/ready stream. New relative to the previous generation: start/done handshake, signed/unsigned mode, cross-tile accumulation, saturation with a sticky flag, and output backpressure.

Parameters:
N, 8, operand width (bits)
M, 20, accumulator/result width (bits), M >= 2N
R, 4, PE rows (filters per tile)
C, 4, PE columns (image vectors per tile)
K, 9, dot-product length (L2 equivalent)
RW, $clog2(R) (min 1), out_row width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous and active-low (sampled on the rising edge of clk)
start  in  1  tile start request; accepted only in IDLE
sgn  in  1  1 = two's-complement operands/results, 0 = unsigned; sampled with start
acc_en  in  1  1 = keep accumulators from the previous tile, 0 = clear them; sampled with start
a_in  in  R*K*N  row operands; a[r][k] at [(r*K+k)*N +: N]; sampled with start
b_in  in  C*K*N  column operands; b[c][k] at [(c*K+k)*N +: N]; sampled with start
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse after the last output beat
out_valid  out  1  result row available
out_ready  in  1  downstream accepts the row
out_row  out  RW  row index of out_data
out_data  out  C*M  acc[out_row][c] at [c*M +: M]
sat_flag  out  1  sticky: some accumulator saturated during the current tile

Behaviour:
- Reset (rst=0 at a clock edge): state goes to IDLE.
  - All accumulators, PE pipeline registers and the feed counter go to 0.
  - busy, done, out_valid, out_row, out_data and sat_flag go to 0.
  - Applies in any state, including mid-FEED or mid-DRAIN; any in-flight tile is discarded and no done pulse is issued.
- FSM has three states: IDLE, FEED, DRAIN.
- IDLE:
  - start=1 latches a_in, b_in, sgn and acc_en, and clears sat_flag.
  - If acc_en=0, all accumulators are cleared.
  - Next state is FEED with t=0.
  - start outside IDLE is ignored. Operand inputs are don't-care after acceptance.
- FEED, cycle t = 0 .. K+R+C-3 (K+R+C-2 cycles):
  - Edge injection: the left edge of row r gets a[r][t-r]; the top edge of column c gets b[c][t-c]. Out-of-range indices inject 0.
  - Each PE registers its a operand rightward and its b operand downward (1-cycle hop). PE(r,c) therefore sees a[r][k] and b[c][k] with k = t-r-c in the same cycle.
  - Each cycle, PE(r,c) adds the product of its two inputs to its accumulator.
- Arithmetic:
  - The product is 2N bits: signed or unsigned per the latched sgn, then sign- or zero-extended to M bits.
  - Each accumulation saturates to the M-bit limits. Signed limits: 2^(M-1)-1 and -2^(M-1). Unsigned limit: 2^M-1.
  - Any saturation event sets sat_flag, which holds until the next accepted start or reset.
- After the FEED cycle with t=K+R+C-3, next state is DRAIN with row index 0.
  - The first out_valid occurs K+R+C-1 cycles after the start-accept edge.
- DRAIN:
  - out_valid=1, out_row = row index, out_data = that row's accumulators.
  - On out_valid & out_ready the row index increments.
  - While out_valid & !out_ready, out_row and out_data stay stable.
  - The handshake on row R-1 moves to IDLE and drops out_valid. done is high in the following cycle (first IDLE cycle).
- busy is high in FEED and DRAIN. start asserted in the cycle done is high is accepted.
- Accumulators persist in IDLE, so acc_en=1 on the next start continues the sum (K-chunk tiling).

Test Plan:
1. Identity, R=C=2, K=3, unsigned: a0=[1,0,0], a1=[0,1,0], b0=[5,6,7], b1=[8,9,10] -> row0={5,8}, row1={6,9}; out_valid first 6 cycles after start-accept; done one cycle after row1 handshake.
2. Sign mode, a all 0xFF, b all 2, K=3, M=20: sgn=1 -> every result 0xFFFFA (-6); sgn=0 -> every result 1530; sat_flag=0 in both.
3. Accumulate: run scenario 1, then rerun with acc_en=1 -> row0={10,16}, row1={12,18}; rerun with acc_en=0 -> original values.
4. Saturation, M=16, sgn=1: a all 0x80, b all 0x80, K=3 -> every result 32767 and sat_flag=1; next start clears sat_flag.
5. Backpressure: hold out_ready=0 for 5 cycles in DRAIN -> out_valid stays 1, out_row/out_data unchanged; start pulses during busy are ignored (no restart, single done).
6. Reset mid-FEED (t=2): rst=0 for one edge -> busy=0, out_valid=0, sat_flag=0, done never pulses; a fresh start then reproduces scenario 1 exactly.
